// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with start/parity/stop validation.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting of each bit.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_calc(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

`ifdef UART_RX_MAJORITY_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_t                    state_r, state_nxt_s;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_r, presc_r;
    logic [PRESCALE_WIDTH-1:0] half_s, last_s;
    logic [BCW-1:0]            bit_cnt_r;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic                      par_en_r, par_typ_r, frame_bad_r;
    logic                      samp_mid_r, bit_r, bit_s;
    logic                      at_mid_s, at_late_s, at_last_s, par_err_s, frame_start_s;
`ifdef UART_RX_MAJORITY_EN
    logic                      samp_early_r;
    logic                      at_early_s;
`endif

    assign half_s        = presc_r >> 1;
    assign last_s        = presc_r - PRESCALE_WIDTH'(1);
    assign at_mid_s      = (edge_cnt_r == half_s);
    assign at_late_s     = (edge_cnt_r == (half_s + PRESCALE_WIDTH'(1)));
    assign at_last_s     = (edge_cnt_r == last_s);
    assign frame_start_s = (state_r == IDLE) && !RX_IN;
`ifdef UART_RX_MAJORITY_EN
    assign at_early_s    = (edge_cnt_r == (half_s - PRESCALE_WIDTH'(1)));
`endif

    // Bit resolution, next-state and parity-check decode.
    always_comb begin
        state_nxt_s = state_r;
`ifdef UART_RX_MAJORITY_EN
        bit_s       = majority3(samp_early_r, samp_mid_r, RX_IN);
`else
        bit_s       = samp_mid_r;
`endif
        par_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!RX_IN) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (at_late_s && bit_s) state_nxt_s = IDLE;
                else if (at_last_s)     state_nxt_s = DATA;
                else                    state_nxt_s = START;
            end
            DATA: begin
                if (at_last_s && (bit_cnt_r == LAST_BIT)) state_nxt_s = par_en_r ? PARITY : STOP;
                else                                      state_nxt_s = DATA;
            end
            PARITY: begin
                if (at_last_s) begin
                    state_nxt_s = STOP;
                    par_err_s   = (bit_r != parity_calc(shift_r, par_typ_r));
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (at_last_s) state_nxt_s = IDLE;
                else           state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_r <= IDLE;
        else      state_r <= state_nxt_s;
    end

    // Bit timing counters and per-frame configuration capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            presc_r     <= '0;
            par_en_r    <= 1'b0;
            par_typ_r   <= 1'b0;
            frame_bad_r <= 1'b0;
        end else begin
            if (state_nxt_s == IDLE)    edge_cnt_r <= '0;
            else if (state_r == IDLE)   edge_cnt_r <= PRESCALE_WIDTH'(1);
            else if (at_last_s)         edge_cnt_r <= '0;
            else                        edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);

            if (frame_start_s) begin
                presc_r     <= Prescale;
                par_en_r    <= PAR_EN;
                par_typ_r   <= PAR_TYP;
                frame_bad_r <= 1'b0;
                bit_cnt_r   <= '0;
            end else if (state_r == DATA && at_last_s) begin
                bit_cnt_r   <= (bit_cnt_r == LAST_BIT) ? '0 : bit_cnt_r + BCW'(1);
            end
            if (par_err_s) frame_bad_r <= 1'b1;
        end
    end

    // Line sampling and payload assembly (LSB first).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_mid_r   <= 1'b0;
            bit_r        <= 1'b0;
            shift_r      <= '0;
`ifdef UART_RX_MAJORITY_EN
            samp_early_r <= 1'b0;
`endif
        end else if (state_r != IDLE) begin
            if (at_mid_s)   samp_mid_r <= RX_IN;
`ifdef UART_RX_MAJORITY_EN
            if (at_early_s) samp_early_r <= RX_IN;
`endif
            if (at_late_s) begin
                bit_r <= bit_s;
                if (state_r == DATA) shift_r[bit_cnt_r] <= bit_s;
            end
        end
    end

    // Registered outputs; error and valid flags are single-cycle pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            Stop_Error   <= 1'b0;
            Parity_Error <= par_err_s;
            if (state_r == STOP && at_last_s) begin
                if (!bit_r) begin
                    Stop_Error <= 1'b1;
                end else if (!frame_bad_r) begin
                    P_DATA     <= shift_r;
                    data_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the SYS_TOP UART clock domain. It oversamples RX_IN by a programmable prescale, validates start, optional parity and stop bits, and presents each good byte as P_DATA with a one-cycle data_valid pulse. Its output feeds the data synchronizer ahead of the system controller, which parses command frames (0xAA, 0xBB, 0xCC, 0xDD).

## Interface
- DATA_WIDTH, 8: payload bits per frame, sent LSB first.
- PRESCALE_WIDTH, 6: width of the Prescale input.
- CLK  input  1  UART oversampling clock; rising-edge logic only.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high; already synchronous to CLK (pad synchronizer upstream).
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; legal values 8, 16, 32.
- P_DATA  output  DATA_WIDTH  last accepted byte; held between frames.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- Parity_Error  output  1  one-cycle pulse on parity mismatch.
- Stop_Error  output  1  one-cycle pulse when the stop bit samples 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN == 0 at a clock edge, go to START. That edge is bit edge 0, so edge_cnt = 1 afterwards. Prescale, PAR_EN and PAR_TYP are latched at this edge; later changes are ignored until the next frame.
- Bit timing: edge_cnt runs 0..P-1 per bit, where P is the latched Prescale. Sample points are edges P/2-1, P/2 and P/2+1. The bit value is the sample at P/2 (or the majority of the three, see Configuration).
- START: if the start bit resolves to 1, it is a glitch. Return to IDLE at edge P/2+1 with no flags. Otherwise go to DATA at edge P-1.
- DATA: shift the resolved bit into bit_cnt position (LSB first). After 8 bits, go to PARITY at edge P-1 if PAR_EN = 1, else go to STOP.
- PARITY: expected parity = XOR of the data bits, XOR PAR_TYP. On mismatch, pulse Parity_Error at edge P-1 and set the internal frame_bad flag. Proceed to STOP in either case, so the receiver stays frame-aligned.
- STOP: at edge P-1, return to IDLE.
  - Stop bit resolved to 0: pulse Stop_Error.
  - Stop bit good and frame_bad clear: load P_DATA from the shift register and pulse data_valid.
  - Any error: P_DATA is unchanged and data_valid stays 0.
- Parity_Error and Stop_Error can both occur in one frame, one cycle pulse each, on different edges.
- Reset, asynchronous at any time including mid-frame:
  - State goes to IDLE; all counters and the shift register go to 0.
  - P_DATA = 0, data_valid = 0, Parity_Error = 0, Stop_Error = 0.
  - On reset release the block waits for a fresh falling level. A partial frame in progress is dropped.

## Timing
- All outputs are registered.
- Let E0 be the edge that first samples RX_IN = 0, and N = 10 + PAR_EN bits per frame.
- data_valid (or Stop_Error) is high for exactly the cycle following edge E0 + N*P - 1.
- Parity_Error is high for the cycle following edge E0 + 10*P - 1.
- Back-to-back frames: a new start bit may be sampled at edge E0 + N*P, the first edge in IDLE. No idle gap is required.
- Start glitch: back in IDLE after edge E0 + P/2 + 1.
- Illegal Prescale values give undefined timing; the FSM must still return to IDLE when RST asserts.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit is the 2-of-3 majority of the samples at edges P/2-1, P/2 and P/2+1.
- UART_RX_MAJORITY_EN undefined: each bit is the single sample at edge P/2. The flops for the other two samples are removed.
- Frame timing and output latency are identical in both builds.

## Test plan
- Good frame, even parity: Prescale = 8, PAR_EN = 1, PAR_TYP = 0; send 0xAA (parity bit 0), then 0x08 (parity bit 1) with a 16-bit idle gap → data_valid pulses 88 cycles after each start edge; P_DATA = 0xAA, then 0x08; no error flags.
- Parity error: send 0x0A with parity bit 1 under even parity → Parity_Error pulse at E0 + 79; no data_valid; P_DATA keeps its previous value.
- Stop error: send 0xCC with stop bit held 0 → Stop_Error pulse at E0 + 87; no data_valid. The following good frame 0xDD is received correctly.
- Start glitch: RX_IN low for 2 cycles, then high; Prescale = 8 → FSM back in IDLE; no outputs pulse. A subsequent 0x03 frame is received.
- Back-to-back without parity: Prescale = 16, PAR_EN = 0; send 0x55 then 0xFF with no idle gap → two data_valid pulses 160 cycles apart, carrying the correct bytes.
- Reset mid-frame: assert RST during the DATA bits of 0xBB → all outputs 0 immediately. After release, a full 0xBB frame yields P_DATA = 0xBB.
